// File: rtl/operand_sequencer.sv
// Host-side sequencer: latches one operand set, strobes it onto a shared bus while the
// controller is in READ, then arms ready and waits for the controller's DONE/valid.
module operand_sequencer #(
    parameter int WIDTH         = 16,
    parameter int STROBE_CYCLES = 2,
    parameter int TIMEOUT       = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] dx_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] u_in,
    input  logic [2:0]       ctrl_state,
    input  logic             ctrl_valid,
    output logic             s1,
    output logic             s2,
    output logic             s3,
    output logic             s4,
    output logic [WIDTH-1:0] data_out,
    output logic             ready,
    output logic             busy,
    output logic             finished,
    output logic             error
);

    typedef enum logic [3:0] {
        IDLE, WAIT_READ, LD_X, LD_DX, LD_A, LD_U, ARM, WAIT_DONE, FIN, ERR
    } state_t;

    localparam logic [2:0] CS_READ    = 3'b001;
    localparam logic [2:0] CS_COMPUTE = 3'b010;
    localparam logic [2:0] CS_DONE    = 3'b110;

    localparam int MAXC = (TIMEOUT > STROBE_CYCLES) ? TIMEOUT : STROBE_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] STROBE_LAST  = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_x, r_dx, r_a, r_u;
    logic [3:0]       w_sel;
    logic [WIDTH-1:0] w_data;
    logic             w_read;
    logic             w_strobe_done;
    logic             w_timeout;

    assign w_read        = (ctrl_state == CS_READ);
    assign w_strobe_done = (r_cnt == STROBE_LAST);
    assign w_timeout     = (r_cnt == TIMEOUT_LAST);

    // Exit conditions are tested before the timeout so a same-cycle exit always wins.
    always_comb begin
        // NOTE: default first so every path assigns w_next; otherwise a latch is inferred.
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (start) w_next = WAIT_READ;
            WAIT_READ: if (w_read) w_next = LD_X;
                       else if (w_timeout) w_next = ERR;
            LD_X:      if (!w_read) w_next = ERR;
                       else if (w_strobe_done) w_next = LD_DX;
            LD_DX:     if (!w_read) w_next = ERR;
                       else if (w_strobe_done) w_next = LD_A;
            LD_A:      if (!w_read) w_next = ERR;
                       else if (w_strobe_done) w_next = LD_U;
            LD_U:      if (!w_read) w_next = ERR;
                       else if (w_strobe_done) w_next = ARM;
            ARM:       if (ctrl_state == CS_COMPUTE) w_next = WAIT_DONE;
                       else if (w_timeout) w_next = ERR;
            WAIT_DONE: if (ctrl_valid || ctrl_state == CS_DONE) w_next = FIN;
                       else if (w_timeout) w_next = ERR;
            FIN:       w_next = IDLE;
            ERR:       w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that registered outputs track the state itself.
    always_comb begin
        w_sel  = 4'b0000;
        w_data = '0;
        unique case (w_next)
            LD_X:    begin w_sel = 4'b0001; w_data = r_x;  end
            LD_DX:   begin w_sel = 4'b0010; w_data = r_dx; end
            LD_A:    begin w_sel = 4'b0100; w_data = r_a;  end
            LD_U:    begin w_sel = 4'b1000; w_data = r_u;  end
            default: begin w_sel = 4'b0000; w_data = '0;   end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_x      <= '0;
            r_dx     <= '0;
            r_a      <= '0;
            r_u      <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            s4       <= 1'b0;
            data_out <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
            error    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next;
            // One shared counter: dwell time in strobe states, timeout in wait states.
            if (w_next != r_state || r_state == IDLE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            if (r_state == IDLE && start) begin
                r_x  <= x_in;
                r_dx <= dx_in;
                r_a  <= a_in;
                r_u  <= u_in;
            end
            s1       <= w_sel[0];
            s2       <= w_sel[1];
            s3       <= w_sel[2];
            s4       <= w_sel[3];
            data_out <= w_data;
            ready    <= (w_next == ARM);
            busy     <= (w_next != IDLE);
            finished <= (w_next == FIN);
            error    <= (w_next == ERR);
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: strobe/data beats and finish/error pulses are
// queued as stimulus is applied and popped by a monitor as the DUT emits them.
module tb_operand_sequencer;

    localparam int W  = 16;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  x_in, dx_in, a_in, u_in;
    logic [2:0]    ctrl_state;
    logic          ctrl_valid;

    logic [3:0]    a_s, b_s;
    logic [W-1:0]  a_data, b_data;
    logic          a_ready, a_busy, a_fin, a_err;
    logic          b_ready, b_busy, b_fin, b_err;

    int            n_vec = 0;
    int            n_err = 0;
    int            fin_seen = 0;
    logic [21:0]   sb[$];

    always #5 clk = ~clk;

    operand_sequencer #(.WIDTH(W), .STROBE_CYCLES(SC), .TIMEOUT(1024)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .x_in(x_in), .dx_in(dx_in), .a_in(a_in), .u_in(u_in),
        .ctrl_state(ctrl_state), .ctrl_valid(ctrl_valid),
        .s1(a_s[0]), .s2(a_s[1]), .s3(a_s[2]), .s4(a_s[3]),
        .data_out(a_data), .ready(a_ready), .busy(a_busy),
        .finished(a_fin), .error(a_err)
    );

    operand_sequencer #(.WIDTH(W), .STROBE_CYCLES(SC), .TIMEOUT(8)) u_dut_to (
        .clk(clk), .reset_n(reset_n), .start(start),
        .x_in(x_in), .dx_in(dx_in), .a_in(a_in), .u_in(u_in),
        .ctrl_state(ctrl_state), .ctrl_valid(ctrl_valid),
        .s1(b_s[0]), .s2(b_s[1]), .s3(b_s[2]), .s4(b_s[3]),
        .data_out(b_data), .ready(b_ready), .busy(b_busy),
        .finished(b_fin), .error(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("onehot", 32'($countones(a_s) <= 1), 32'd1);
            if (a_s == 4'b0000) check("data_idle", 32'(a_data), 32'd0);
            if (a_s != 4'b0000 || a_fin || a_err) begin
                if (a_fin) fin_seen++;
                if (sb.size() == 0)
                    check("sb_unexpected", 32'({a_err, a_fin, a_s, a_data}), 32'd0);
                else
                    check("sb", 32'({a_err, a_fin, a_s, a_data}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [3:0] sel, input logic [W-1:0] d, input int n);
        repeat (n) sb.push_back({2'b00, sel, d});
    endtask

    task automatic push_load(input logic [W-1:0] x, dx, a, u);
        push_op(4'b0001, x,  SC);
        push_op(4'b0010, dx, SC);
        push_op(4'b0100, a,  SC);
        push_op(4'b1000, u,  SC);
    endtask

    task automatic push_fin();
        sb.push_back({2'b01, 4'b0000, 16'h0000});
    endtask

    task automatic push_err();
        sb.push_back({2'b10, 4'b0000, 16'h0000});
    endtask

    task automatic do_reset(input string tag);
        reset_n    = 1'b0;
        start      = 1'b0;
        ctrl_state = 3'b000;
        ctrl_valid = 1'b0;
        step();
        step();
        check({tag, "_rst_a"}, 32'({a_s, a_data, a_ready, a_busy, a_fin, a_err}), 32'd0);
        check({tag, "_rst_b"}, 32'({b_s, b_data, b_ready, b_busy, b_fin, b_err}), 32'd0);
        reset_n = 1'b1;
        step();
    endtask

    // Pulses start for one edge, then scrambles the host operand inputs.
    task automatic fire(input logic [W-1:0] x, dx, a, u);
        x_in  = x;
        dx_in = dx;
        a_in  = a;
        u_in  = u;
        start = 1'b1;
        step();
        start = 1'b0;
        x_in  = W'($urandom);
        dx_in = W'($urandom);
        a_in  = W'($urandom);
        u_in  = W'($urandom);
    endtask

    function automatic logic pick(input int which);
        case (which)
            0, 1, 2, 3: return a_s[which];
            4:          return a_ready;
            5:          return b_ready;
            6:          return b_err;
            default:    return a_fin;
        endcase
    endfunction

    task automatic wait_bit(input int which, input int budget, input string tag, output int cyc);
        cyc = 0;
        while (!pick(which) && cyc < budget) begin
            step();
            cyc++;
        end
        if (!pick(which)) check({tag, "_expired"}, 32'd0, 32'd1);
    endtask

    initial begin
        int cyc;
        int f0;
        x_in = '0; dx_in = '0; a_in = '0; u_in = '0;

        // 1. nominal sequence
        do_reset("t1");
        ctrl_state = 3'b001;
        push_load(16'h0010, 16'h0001, 16'h0003, 16'h0005);
        push_fin();
        fire(16'h0010, 16'h0001, 16'h0003, 16'h0005);
        wait_bit(0, 50, "t1_s1", cyc);
        check("t1_lat_s1", 32'(cyc + 1), 32'd2);
        wait_bit(4, 50, "t1_ready", cyc);
        check("t1_lat_ready", 32'(cyc), 32'(4 * SC));
        check("t1_busy", 32'(a_busy), 32'd1);
        repeat (3) begin
            step();
            check("t1_ready_hold", 32'(a_ready), 32'd1);
        end
        ctrl_state = 3'b010;
        step();
        check("t1_ready_drop", 32'(a_ready), 32'd0);
        repeat (20) step();
        check("t1_no_early_fin", 32'(a_fin), 32'd0);
        check("t1_busy_wait", 32'(a_busy), 32'd1);
        ctrl_valid = 1'b1;
        ctrl_state = 3'b110;
        step();
        check("t1_fin", 32'(a_fin), 32'd1);
        ctrl_valid = 1'b0;
        ctrl_state = 3'b000;
        step();
        check("t1_fin_pulse", 32'(a_fin), 32'd0);
        check("t1_idle", 32'(a_busy), 32'd0);
        check("t1_drain", 32'(sb.size()), 32'd0);

        // 2. late READ from the controller
        do_reset("t2");
        push_load(16'h1234, 16'h00FF, 16'hA5A5, 16'h8001);
        push_fin();
        fire(16'h1234, 16'h00FF, 16'hA5A5, 16'h8001);
        repeat (5) begin
            step();
            check("t2_no_strobe", 32'(a_s), 32'd0);
        end
        ctrl_state = 3'b001;
        step();
        check("t2_s1", 32'(a_s), 32'd1);
        wait_bit(4, 50, "t2_ready", cyc);
        check("t2_lat_ready", 32'(cyc), 32'(4 * SC));
        ctrl_state = 3'b010;
        step();
        ctrl_valid = 1'b1;
        step();
        check("t2_fin", 32'(a_fin), 32'd1);
        ctrl_valid = 1'b0;
        ctrl_state = 3'b000;
        step();
        check("t2_idle", 32'(a_busy), 32'd0);
        check("t2_drain", 32'(sb.size()), 32'd0);

        // 3. timeout in WAIT_DONE (second instance, TIMEOUT=8)
        do_reset("t3");
        ctrl_state = 3'b001;
        push_load(16'h0BAD, 16'h0C0D, 16'h0E0F, 16'h0102);
        fire(16'h0BAD, 16'h0C0D, 16'h0E0F, 16'h0102);
        wait_bit(5, 50, "t3_ready", cyc);
        ctrl_state = 3'b010;
        step();
        wait_bit(6, 30, "t3_err", cyc);
        check("t3_timeout_cycles", 32'(cyc), 32'd8);
        check("t3_no_fin", 32'(b_fin), 32'd0);
        step();
        check("t3_err_pulse", 32'(b_err), 32'd0);
        check("t3_idle", 32'(b_busy), 32'd0);
        check("t3_fin_stays_low", 32'(b_fin), 32'd0);
        check("t3_long_timeout_busy", 32'(a_busy), 32'd1);
        check("t3_drain", 32'(sb.size()), 32'd0);

        // 4. controller leaves READ during LD_A
        do_reset("t4");
        ctrl_state = 3'b001;
        push_op(4'b0001, 16'h1111, SC);
        push_op(4'b0010, 16'h2222, SC);
        push_op(4'b0100, 16'h3333, 1);
        push_err();
        fire(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        wait_bit(2, 50, "t4_s3", cyc);
        ctrl_state = 3'b000;
        step();
        check("t4_s_drop", 32'(a_s), 32'd0);
        check("t4_err", 32'(a_err), 32'd1);
        check("t4_no_ready", 32'(a_ready), 32'd0);
        step();
        check("t4_err_pulse", 32'(a_err), 32'd0);
        check("t4_idle", 32'(a_busy), 32'd0);
        repeat (3) step();
        check("t4_drain", 32'(sb.size()), 32'd0);

        // 5. asynchronous reset while s2 is high, then restart
        do_reset("t5");
        ctrl_state = 3'b001;
        push_op(4'b0001, 16'h5A5A, SC);
        push_op(4'b0010, 16'h6B6B, 1);
        fire(16'h5A5A, 16'h6B6B, 16'h7C7C, 16'h8D8D);
        wait_bit(1, 50, "t5_s2", cyc);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_async_a", 32'({a_s, a_data, a_ready, a_busy, a_fin, a_err}), 32'd0);
        check("t5_async_b", 32'({b_s, b_data, b_ready, b_busy, b_fin, b_err}), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        push_load(16'hCAFE, 16'hBEEF, 16'hF00D, 16'h0042);
        push_fin();
        fire(16'hCAFE, 16'hBEEF, 16'hF00D, 16'h0042);
        wait_bit(0, 50, "t5_s1", cyc);
        check("t5_lat_s1", 32'(cyc + 1), 32'd2);
        wait_bit(4, 50, "t5_ready", cyc);
        ctrl_state = 3'b010;
        step();
        ctrl_valid = 1'b1;
        step();
        check("t5_fin", 32'(a_fin), 32'd1);
        ctrl_valid = 1'b0;
        ctrl_state = 3'b000;
        step();
        check("t5_drain", 32'(sb.size()), 32'd0);

        // 6. start during WAIT_DONE is ignored
        do_reset("t6");
        ctrl_state = 3'b001;
        push_load(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        push_fin();
        f0 = fin_seen;
        fire(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        wait_bit(4, 50, "t6_ready", cyc);
        ctrl_state = 3'b010;
        step();
        fire(16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC);
        repeat (3) step();
        check("t6_still_waiting", 32'(a_busy), 32'd1);
        check("t6_no_strobe", 32'(a_s), 32'd0);
        ctrl_valid = 1'b1;
        step();
        ctrl_valid = 1'b0;
        ctrl_state = 3'b000;
        repeat (10) step();
        check("t6_one_fin", 32'(fin_seen - f0), 32'd1);
        check("t6_idle", 32'(a_busy), 32'd0);
        check("t6_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
